// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder controller that drives a single external full_adder.
//   Operands are captured over a valid/ready handshake. One bit-slice per
//   cycle is then presented to the full adder, LSB first, and its sum and
//   carry are captured. The finished WIDTH-bit sum and carry-out are
//   returned over a second valid/ready handshake. This trades latency
//   (WIDTH cycles per add) for area: one full adder serves any WIDTH.
//
// Ports
//   clk_i        in   1      rising-edge clock
//   rst_i        in   1      asynchronous active-high reset
//   in_valid_i   in   1      operand request valid
//   in_ready_o   out  1      operands can be accepted (IDLE only)
//   a_i, b_i     in   WIDTH  operands
//   cin_i        in   1      carry-in
//   fa_abc_o     out  3      to full adder: {carry, b bit, a bit}
//   fa_sum_i     in   1      full adder sum
//   fa_carry_i   in   1      full adder carry
//   out_valid_o  out  1      result valid (DONE only)
//   out_ready_i  in   1      downstream takes the result
//   sum_o        out  WIDTH  result sum
//   cout_o       out  1      result carry-out
//   busy_o       out  1      operation in progress or result pending
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic [2:0]       fa_abc_o,
   input  logic             fa_sum_i,
   input  logic             fa_carry_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             busy_o
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic             carry_q;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             last_slice;

   // State register. Reset drops straight back to IDLE, which abandons
   // any operation in flight without producing a result.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and handshake decode. All outputs are decoded from the
   // registered state only, so in_ready_o never depends combinationally
   // on out_ready_i. The full adder sees zeros whenever no slice is being
   // processed, so it does not toggle while the block is idle or stalled.
   always_comb begin
      next_state  = state;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      busy_o      = 1'b0;
      fa_abc_o    = 3'b000;
      accept      = 1'b0;
      last_slice  = (cnt == LAST_CNT);
      case (state)
         IDLE: begin
            in_ready_o = 1'b1;
            accept     = in_valid_i;
            if (in_valid_i) begin
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            busy_o   = 1'b1;
            fa_abc_o = {carry_q, b_sh[0], a_sh[0]};
            if (last_slice) begin
               next_state = DONE;
            end
         end
         DONE: begin
            busy_o      = 1'b1;
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Datapath. On accept the operands and carry-in are loaded and the
   // result register is cleared. Each SHIFT cycle consumes the LSB of both
   // operands and pushes the new sum bit in at the top, so after WIDTH
   // cycles the first sum bit has reached bit 0. carry_q doubles as the
   // running carry and, once finished, as the carry-out. The counter holds
   // on the last slice instead of wrapping; it is reloaded on the next
   // accept. Nothing changes in IDLE or DONE, so the last result stays
   // visible until the next operation is accepted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         a_sh    <= '0;
         b_sh    <= '0;
         sum_sh  <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
      end else if (accept) begin
         a_sh    <= a_i;
         b_sh    <= b_i;
         sum_sh  <= '0;
         carry_q <= cin_i;
         cnt     <= '0;
      end else if (state == SHIFT) begin
         a_sh    <= a_sh >> 1;
         b_sh    <= b_sh >> 1;
         sum_sh  <= {fa_sum_i, sum_sh[WIDTH-1:1]};
         carry_q <= fa_carry_i;
         if (!last_slice) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign sum_o  = sum_sh;
   assign cout_o = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
//   Bench for serial_add_ctrl with WIDTH=8. The external full adder is
//   modelled with two continuous assigns. Expected results come from
//   plain integer addition of the operands. Expected bit-slices come from
//   the carry into each bit position of that same addition.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic [2:0]   fa_abc;
   logic         fa_sum;
   logic         fa_carry;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;

   int vectors;
   int miscompares;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .a_i         (a),
      .b_i         (b),
      .cin_i       (cin),
      .fa_abc_o    (fa_abc),
      .fa_sum_i    (fa_sum),
      .fa_carry_i  (fa_carry),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .sum_o       (sum),
      .cout_o      (cout),
      .busy_o      (busy)
   );

   // Full adder attached downstream of the controller.
   assign fa_sum   = ^fa_abc;
   assign fa_carry = (fa_abc[0] & fa_abc[1]) | (fa_abc[0] & fa_abc[2]) | (fa_abc[1] & fa_abc[2]);

   // Free-running clock with a 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference result: the full-precision sum a + b + cin.
   function automatic logic [W:0] ref_sum(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
      return {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
   endfunction

   // Carry into bit k: the sum of the operands' low k bits plus cin, shifted down by k.
   function automatic logic carry_into(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input int k);
      longint unsigned mask;
      longint unsigned s;
      mask = (64'd1 << k) - 64'd1;
      s = (longint'(av) & mask) + (longint'(bv) & mask) + longint'(cv);
      return s[k];
   endfunction

   // Presents operands until accepted. On return the time is just after the accept edge.
   task automatic send_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, output bit ok);
      ok = 1'b0;
      a = av;
      b = bv;
      cin = cv;
      in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (in_ready) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   // Waits for out_valid and returns the number of edges that took (at most 100).
   task automatic wait_done(output int cycles);
      cycles = 0;
      while (!out_valid && cycles < 100) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   // Takes the pending result in a single cycle.
   task automatic collect();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
      vectors++; if (sum !== '0) begin miscompares++; $display("[TB] FAIL reset_sum got=%h exp=00", sum); end
      vectors++; if (cout !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cout got=%b exp=0", cout); end
      vectors++; if (fa_abc !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_fa_abc got=%b exp=000", fa_abc); end
      rst = 1'b0;
      @(posedge clk);
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_basic_add();
      bit ok;
      logic [W:0] exp;
      logic [W-1:0] av;
      logic [W-1:0] bv;
      av = 8'h5A;
      bv = 8'h3C;
      exp = ref_sum(av, bv, 1'b0);
      send_op(av, bv, 1'b0, ok);
      vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL basic_accept got=timeout exp=accept"); end
      for (int k = 0; k < W; k++) begin
         vectors++;
         if (fa_abc !== {carry_into(av, bv, 1'b0, k), bv[k], av[k]}) begin
            miscompares++;
            $display("[TB] FAIL basic_slice%0d got=%b exp=%b", k, fa_abc, {carry_into(av, bv, 1'b0, k), bv[k], av[k]});
         end
         vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_early_valid%0d got=%b exp=0", k, out_valid); end
         @(posedge clk);
         #1;
      end
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_latency got=%b exp=1", out_valid); end
      vectors++; if ({cout, sum} !== exp) begin miscompares++; $display("[TB] FAIL basic_result got=%h exp=%h", {cout, sum}, exp); end
      vectors++; if (exp !== 9'h096) begin miscompares++; $display("[TB] FAIL basic_model got=%h exp=096", exp); end
      vectors++; if (fa_abc !== 3'b000) begin miscompares++; $display("[TB] FAIL basic_done_fa_abc got=%b exp=000", fa_abc); end
      collect();
   endtask

   task automatic test_overflow();
      bit ok;
      int cycles;
      send_op(8'hFF, 8'h01, 1'b0, ok);
      wait_done(cycles);
      vectors++; if (!ok || cycles != W) begin miscompares++; $display("[TB] FAIL ovf1_latency got=%0d exp=%0d", cycles, W); end
      vectors++; if (sum !== 8'h00 || cout !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf1_result got=%b_%h exp=1_00", cout, sum); end
      collect();
      send_op(8'hFF, 8'hFF, 1'b1, ok);
      wait_done(cycles);
      vectors++; if (!ok || cycles != W) begin miscompares++; $display("[TB] FAIL ovf2_latency got=%0d exp=%0d", cycles, W); end
      vectors++; if (sum !== 8'hFF || cout !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf2_result got=%b_%h exp=1_ff", cout, sum); end
      collect();
   endtask

   task automatic test_backpressure();
      bit ok;
      int cycles;
      logic [W:0] exp;
      exp = ref_sum(8'hC3, 8'h7E, 1'b1);
      send_op(8'hC3, 8'h7E, 1'b1, ok);
      wait_done(cycles);
      vectors++; if (!ok || cycles != W) begin miscompares++; $display("[TB] FAIL bp_latency got=%0d exp=%0d", cycles, W); end
      a = 8'h11;
      b = 8'h22;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_valid%0d got=%b exp=1", i, out_valid); end
         vectors++; if ({cout, sum} !== exp) begin miscompares++; $display("[TB] FAIL bp_hold%0d got=%h exp=%h", i, {cout, sum}, exp); end
         vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_in_ready%0d got=%b exp=0", i, in_ready); end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      collect();
      vectors++; if (in_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_release got=%b%b exp=10", in_ready, busy); end
      vectors++; if ({cout, sum} !== exp) begin miscompares++; $display("[TB] FAIL bp_idle_keep got=%h exp=%h", {cout, sum}, exp); end
   endtask

   task automatic test_ignore_in_shift();
      bit ok;
      int cycles;
      logic [W:0] exp1;
      logic [W:0] exp2;
      exp1 = ref_sum(8'h21, 8'h43, 1'b0);
      exp2 = ref_sum(8'h9C, 8'hA5, 1'b1);
      send_op(8'h21, 8'h43, 1'b0, ok);
      a = 8'h9C;
      b = 8'hA5;
      cin = 1'b1;
      in_valid = 1'b1;
      wait_done(cycles);
      vectors++; if (!ok || cycles != W) begin miscompares++; $display("[TB] FAIL ign_latency got=%0d exp=%0d", cycles, W); end
      vectors++; if ({cout, sum} !== exp1) begin miscompares++; $display("[TB] FAIL ign_first_result got=%h exp=%h", {cout, sum}, exp1); end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL ign_idle got=%b%b exp=10", in_ready, out_valid); end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      vectors++; if (busy !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ign_second_accept got=%b%b exp=10", busy, in_ready); end
      wait_done(cycles);
      vectors++; if (cycles != W) begin miscompares++; $display("[TB] FAIL ign_second_latency got=%0d exp=%0d", cycles, W); end
      vectors++; if ({cout, sum} !== exp2) begin miscompares++; $display("[TB] FAIL ign_second_result got=%h exp=%h", {cout, sum}, exp2); end
      collect();
   endtask

   task automatic test_reset_mid_op();
      bit ok;
      int cycles;
      send_op(8'hE7, 8'h5B, 1'b1, ok);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_busy got=%b exp=0", busy); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
      vectors++; if ({cout, sum, fa_abc} !== '0) begin miscompares++; $display("[TB] FAIL rst_mid_regs got=%b_%h_%b exp=0_00_000", cout, sum, fa_abc); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      send_op(8'h10, 8'h20, 1'b0, ok);
      wait_done(cycles);
      vectors++; if (!ok || cycles != W) begin miscompares++; $display("[TB] FAIL rst_next_latency got=%0d exp=%0d", cycles, W); end
      vectors++; if (sum !== 8'h30 || cout !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_next_result got=%b_%h exp=0_30", cout, sum); end
      collect();
   endtask

   task automatic test_random();
      bit ok;
      int cycles;
      int gap;
      int stall;
      logic [W-1:0] av;
      logic [W-1:0] bv;
      logic cv;
      logic [W:0] exp;
      for (int n = 0; n < 1000; n++) begin
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            vectors++; if (fa_abc !== 3'b000 || in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rnd_idle op%0d got=%b_%b exp=000_1", n, fa_abc, in_ready); end
            @(posedge clk);
            #1;
         end
         av = W'($urandom);
         bv = W'($urandom);
         cv = 1'($urandom);
         exp = ref_sum(av, bv, cv);
         send_op(av, bv, cv, ok);
         wait_done(cycles);
         vectors++; if (!ok || cycles != W) begin miscompares++; $display("[TB] FAIL rnd_latency op%0d got=%0d exp=%0d", n, cycles, W); end
         stall = 0;
         do begin
            out_ready = 1'($urandom_range(0, 1)) | (stall >= 10);
            vectors++;
            if ({cout, sum} !== exp || fa_abc !== 3'b000 || out_valid !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL rnd_result op%0d a=%h b=%h cin=%b got=%h/%b/%b exp=%h/000/1", n, av, bv, cv, {cout, sum}, fa_abc, out_valid, exp);
            end
            @(posedge clk);
            #1;
            stall++;
         end while (!out_ready);
         out_ready = 1'b0;
      end
   endtask

   // Runs each scenario in turn and prints the summary.
   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;
      test_reset();
      test_basic_add();
      test_overflow();
      test_backpressure();
      test_ignore_in_shift();
      test_reset_mid_op();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
